// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and defaults for the pipeline sequencer.
// Imported by pipeline_ctrl and its testbench.
package pipe_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_FILL   = 3'd0,
      ST_RUN    = 3'd1,
      ST_BR_EX  = 3'd2,
      ST_BR_MEM = 3'd3,
      ST_DRAIN  = 3'd4,
      ST_HALTED = 3'd5
   } ctrl_state_e;

   localparam logic [7:0] NOP_OP = 8'h00;

   localparam int FILL_CYCLES_DEF  = 4;
   localparam int DRAIN_CYCLES_DEF = 3;
   localparam int CNT_W_DEF        = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with async active-low reset.
// Holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         clear,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: fill, load-use stall, branch wait, drain/halt.
// Produces PC and pipeline-register enables only; no data path.
module pipeline_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int FILL_CYCLES  = FILL_CYCLES_DEF,
   parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
   parameter int CNT_W        = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic             id_reads_a,
   input  logic             id_reads_b,
   input  logic             id_is_ctrl,
   input  logic             ex_valid,
   input  logic             ex_writes_a,
   input  logic             ex_writes_b,
   input  logic             ex_is_load,
   input  logic             mem_redirect,
   input  logic             halt_req,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             if_id_bubble,
   output logic             id_ex_bubble,
   output logic [2:0]       state,
   output logic             halted,
   output logic             proto_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] ctrl_cnt
);

   localparam logic [7:0] FILL_LAST  = 8'(FILL_CYCLES - 1);
   localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYCLES - 1);

   ctrl_state_e state_q;
   ctrl_state_e state_d;
   logic [7:0]  seq_q;
   logic [7:0]  seq_d;
   logic        load_use;
   logic        ctrl_inc;
   logic        stall_inc;
   logic        cnt_clear;

   assign load_use = id_valid & ex_valid & ex_is_load &
                     ((id_reads_a & ex_writes_a) |
                      (id_reads_b & ex_writes_b));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_FILL;
         seq_q     <= '0;
         halted    <= 1'b0;
         proto_err <= 1'b0;
      end else begin
         state_q   <= state_d;
         seq_q     <= seq_d;
         halted    <= (state_d == ST_HALTED);
         proto_err <= proto_err |
                      (mem_redirect & (state_q != ST_BR_MEM));
      end
   end

   always_comb begin
      state_d      = state_q;
      seq_d        = seq_q;
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      if_id_bubble = 1'b1;
      id_ex_bubble = 1'b1;
      ctrl_inc     = 1'b0;
      case (state_q)
         ST_FILL: begin
            if (seq_q == FILL_LAST) begin
               state_d = ST_RUN;
               seq_d   = '0;
            end else begin
               seq_d = seq_q + 8'd1;
            end
         end
         ST_RUN: begin
            if (load_use) begin
               if_id_bubble = 1'b0;
            end else if (id_valid && id_is_ctrl) begin
               if_id_en     = 1'b1;
               id_ex_bubble = 1'b0;
               ctrl_inc     = 1'b1;
               state_d      = ST_BR_EX;
            end else if (halt_req) begin
               // ID instruction still issues; fetch stops here
               if_id_en     = 1'b1;
               id_ex_bubble = 1'b0;
               state_d      = ST_DRAIN;
               seq_d        = '0;
            end else begin
               pc_en        = 1'b1;
               if_id_en     = 1'b1;
               if_id_bubble = 1'b0;
               id_ex_bubble = 1'b0;
            end
         end
         ST_BR_EX: begin
            if_id_en     = 1'b1;
            id_ex_bubble = 1'b0;
            state_d      = ST_BR_MEM;
         end
         ST_BR_MEM: begin
            pc_en        = 1'b1;
            if_id_en     = 1'b1;
            if_id_bubble = 1'b0;
            id_ex_bubble = 1'b0;
            state_d      = ST_RUN;
         end
         ST_DRAIN: begin
            if_id_en = 1'b1;
            if (seq_q == DRAIN_LAST) begin
               state_d = ST_HALTED;
               seq_d   = '0;
            end else begin
               seq_d = seq_q + 8'd1;
            end
         end
         ST_HALTED: begin
            if (!halt_req) begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_FILL;
            seq_d   = '0;
         end
      endcase
   end

   assign state     = state_q;
   assign cnt_clear = (state_q == ST_FILL);
   assign stall_inc = ~pc_en & ((state_q == ST_RUN) |
                                (state_q == ST_BR_EX) |
                                (state_q == ST_BR_MEM));

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (reset),
      .inc   (stall_inc),
      .clear (cnt_clear),
      .count (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_ctrl_cnt (
      .clk   (clk),
      .rst_n (reset),
      .inc   (ctrl_inc),
      .clear (cnt_clear),
      .count (ctrl_cnt)
   );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl.
// A second instance with CNT_W=4 shares stimulus to show saturation.
module tb_pipeline_ctrl;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic id_valid, id_reads_a, id_reads_b, id_is_ctrl;
   logic ex_valid, ex_writes_a, ex_writes_b, ex_is_load;
   logic mem_redirect, halt_req;

   logic pc_en, if_id_en, if_id_bubble, id_ex_bubble;
   logic [2:0] state;
   logic halted, proto_err;
   logic [15:0] stall_cnt, ctrl_cnt;

   logic s_pc_en, s_if_id_en, s_if_id_bubble, s_id_ex_bubble;
   logic [2:0] s_state;
   logic s_halted, s_proto_err;
   logic [3:0] s_stall_cnt, s_ctrl_cnt;

   int n_chk = 0;
   int n_fail = 0;

   localparam logic [2:0] FILL = 3'd0, RUN = 3'd1, BR_EX = 3'd2;
   localparam logic [2:0] BR_MEM = 3'd3, DRAIN = 3'd4, HALTED = 3'd5;

   always #5 clk = ~clk;

   pipeline_ctrl #(.FILL_CYCLES(4), .DRAIN_CYCLES(3), .CNT_W(16)) dut (
      .clk(clk), .reset(reset),
      .id_valid(id_valid), .id_reads_a(id_reads_a),
      .id_reads_b(id_reads_b), .id_is_ctrl(id_is_ctrl),
      .ex_valid(ex_valid), .ex_writes_a(ex_writes_a),
      .ex_writes_b(ex_writes_b), .ex_is_load(ex_is_load),
      .mem_redirect(mem_redirect), .halt_req(halt_req),
      .pc_en(pc_en), .if_id_en(if_id_en),
      .if_id_bubble(if_id_bubble), .id_ex_bubble(id_ex_bubble),
      .state(state), .halted(halted), .proto_err(proto_err),
      .stall_cnt(stall_cnt), .ctrl_cnt(ctrl_cnt)
   );

   pipeline_ctrl #(.FILL_CYCLES(4), .DRAIN_CYCLES(3), .CNT_W(4)) dut4 (
      .clk(clk), .reset(reset),
      .id_valid(id_valid), .id_reads_a(id_reads_a),
      .id_reads_b(id_reads_b), .id_is_ctrl(id_is_ctrl),
      .ex_valid(ex_valid), .ex_writes_a(ex_writes_a),
      .ex_writes_b(ex_writes_b), .ex_is_load(ex_is_load),
      .mem_redirect(mem_redirect), .halt_req(halt_req),
      .pc_en(s_pc_en), .if_id_en(s_if_id_en),
      .if_id_bubble(s_if_id_bubble), .id_ex_bubble(s_id_ex_bubble),
      .state(s_state), .halted(s_halted), .proto_err(s_proto_err),
      .stall_cnt(s_stall_cnt), .ctrl_cnt(s_ctrl_cnt)
   );

   task automatic clear_inputs();
      id_valid = 0; id_reads_a = 0; id_reads_b = 0; id_is_ctrl = 0;
      ex_valid = 0; ex_writes_a = 0; ex_writes_b = 0; ex_is_load = 0;
      mem_redirect = 0; halt_req = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_load_use_a();
      id_valid = 1; id_reads_a = 1;
      ex_valid = 1; ex_is_load = 1; ex_writes_a = 1;
   endtask

   // reset and wait out the fill so the DUT sits in RUN
   task automatic reset_to_run();
      clear_inputs();
      reset = 0;
      repeat (3) @(posedge clk);
      #1 reset = 1;
      repeat (4) tick();
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 0;
      repeat (3) @(posedge clk);
      #1;
      n_chk++;
      if (state !== FILL || pc_en !== 0 || if_id_en !== 0 ||
          if_id_bubble !== 1 || id_ex_bubble !== 1) begin
         $display("FAIL reset_outputs: st=%0d pc=%b ife=%b ifb=%b idb=%b",
                  state, pc_en, if_id_en, if_id_bubble, id_ex_bubble);
         n_fail++;
      end
      n_chk++;
      if (halted !== 0 || proto_err !== 0 || stall_cnt !== 0 ||
          ctrl_cnt !== 0) begin
         $display("FAIL reset_regs: halted=%b perr=%b stall=%0d ctrl=%0d",
                  halted, proto_err, stall_cnt, ctrl_cnt);
         n_fail++;
      end
      reset = 1;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_chk++;
         if (state !== FILL || pc_en !== 0) begin
            $display("FAIL fill_cycle%0d: st=%0d pc=%b want st=0 pc=0",
                     i, state, pc_en);
            n_fail++;
         end
         tick();
      end
      n_chk++;
      if (state !== RUN || pc_en !== 1 || stall_cnt !== 0 ||
          ctrl_cnt !== 0) begin
         $display("FAIL fill_exit: st=%0d pc=%b stall=%0d ctrl=%0d want 1,1,0,0",
                  state, pc_en, stall_cnt, ctrl_cnt);
         n_fail++;
      end
   endtask

   task automatic test_load_use();
      reset_to_run();
      id_valid = 1; id_reads_b = 1;
      ex_valid = 1; ex_is_load = 1; ex_writes_a = 1;
      #1;
      n_chk++;
      if (pc_en !== 1) begin
         $display("FAIL no_hazard_ab: pc=%b want 1", pc_en);
         n_fail++;
      end
      clear_inputs();
      set_load_use_a();
      #1;
      n_chk++;
      if (pc_en !== 0 || if_id_en !== 0 || id_ex_bubble !== 1) begin
         $display("FAIL load_use_stall: pc=%b ife=%b idb=%b want 0,0,1",
                  pc_en, if_id_en, id_ex_bubble);
         n_fail++;
      end
      tick();
      clear_inputs();
      #1;
      n_chk++;
      if (state !== RUN || stall_cnt !== 1 || pc_en !== 1) begin
         $display("FAIL load_use_after: st=%0d stall=%0d pc=%b want 1,1,1",
                  state, stall_cnt, pc_en);
         n_fail++;
      end
   endtask

   task automatic test_ctrl();
      reset_to_run();
      id_valid = 1; id_is_ctrl = 1;
      #1;
      n_chk++;
      if (pc_en !== 0 || if_id_en !== 1 || if_id_bubble !== 1 ||
          id_ex_bubble !== 0) begin
         $display("FAIL ctrl_run: pc=%b ife=%b ifb=%b idb=%b want 0,1,1,0",
                  pc_en, if_id_en, if_id_bubble, id_ex_bubble);
         n_fail++;
      end
      tick();
      clear_inputs();
      #1;
      n_chk++;
      if (state !== BR_EX || pc_en !== 0 || if_id_bubble !== 1 ||
          id_ex_bubble !== 0) begin
         $display("FAIL ctrl_br_ex: st=%0d pc=%b ifb=%b idb=%b want 2,0,1,0",
                  state, pc_en, if_id_bubble, id_ex_bubble);
         n_fail++;
      end
      tick();
      mem_redirect = 1;
      #1;
      n_chk++;
      if (state !== BR_MEM || pc_en !== 1 || if_id_bubble !== 0) begin
         $display("FAIL ctrl_br_mem: st=%0d pc=%b ifb=%b want 3,1,0",
                  state, pc_en, if_id_bubble);
         n_fail++;
      end
      tick();
      mem_redirect = 0;
      #1;
      n_chk++;
      if (state !== RUN || ctrl_cnt !== 1 || stall_cnt !== 2 ||
          proto_err !== 0) begin
         $display("FAIL ctrl_done: st=%0d ctrl=%0d stall=%0d perr=%b want 1,1,2,0",
                  state, ctrl_cnt, stall_cnt, proto_err);
         n_fail++;
      end
   endtask

   task automatic test_load_and_ctrl();
      reset_to_run();
      set_load_use_a();
      id_is_ctrl = 1;
      #1;
      n_chk++;
      if (pc_en !== 0 || if_id_en !== 0 || id_ex_bubble !== 1) begin
         $display("FAIL lc_stall: pc=%b ife=%b idb=%b want 0,0,1",
                  pc_en, if_id_en, id_ex_bubble);
         n_fail++;
      end
      tick();
      ex_valid = 0; ex_is_load = 0; ex_writes_a = 0;
      #1;
      n_chk++;
      if (state !== RUN || ctrl_cnt !== 0 || id_ex_bubble !== 0) begin
         $display("FAIL lc_issue: st=%0d ctrl=%0d idb=%b want 1,0,0",
                  state, ctrl_cnt, id_ex_bubble);
         n_fail++;
      end
      tick();
      clear_inputs();
      n_chk++;
      if (state !== BR_EX || ctrl_cnt !== 1) begin
         $display("FAIL lc_br_ex: st=%0d ctrl=%0d want 2,1", state, ctrl_cnt);
         n_fail++;
      end
      repeat (2) tick();
      n_chk++;
      if (state !== RUN || ctrl_cnt !== 1) begin
         $display("FAIL lc_done: st=%0d ctrl=%0d want 1,1", state, ctrl_cnt);
         n_fail++;
      end
   endtask

   task automatic test_halt();
      reset_to_run();
      halt_req = 1;
      tick();
      for (int i = 0; i < 3; i++) begin
         n_chk++;
         if (state !== DRAIN || pc_en !== 0 || halted !== 0 ||
             if_id_bubble !== 1 || id_ex_bubble !== 1) begin
            $display("FAIL drain%0d: st=%0d pc=%b hlt=%b ifb=%b idb=%b",
                     i, state, pc_en, halted, if_id_bubble, id_ex_bubble);
            n_fail++;
         end
         tick();
      end
      n_chk++;
      if (state !== HALTED || halted !== 1 || pc_en !== 0 ||
          if_id_en !== 0) begin
         $display("FAIL halted: st=%0d hlt=%b pc=%b ife=%b want 5,1,0,0",
                  state, halted, pc_en, if_id_en);
         n_fail++;
      end
      tick();
      n_chk++;
      if (state !== HALTED || halted !== 1) begin
         $display("FAIL halted_hold: st=%0d hlt=%b want 5,1", state, halted);
         n_fail++;
      end
      halt_req = 0;
      tick();
      n_chk++;
      if (state !== RUN || halted !== 0 || pc_en !== 1) begin
         $display("FAIL halt_exit: st=%0d hlt=%b pc=%b want 1,0,1",
                  state, halted, pc_en);
         n_fail++;
      end
   endtask

   task automatic test_halt_drop();
      reset_to_run();
      halt_req = 1;
      tick();
      halt_req = 0;
      repeat (3) tick();
      n_chk++;
      if (state !== HALTED || halted !== 1) begin
         $display("FAIL drop_halted: st=%0d hlt=%b want 5,1", state, halted);
         n_fail++;
      end
      tick();
      n_chk++;
      if (state !== RUN || halted !== 0) begin
         $display("FAIL drop_exit: st=%0d hlt=%b want 1,0", state, halted);
         n_fail++;
      end
   endtask

   task automatic test_proto_err_and_reset();
      reset_to_run();
      mem_redirect = 1;
      tick();
      mem_redirect = 0;
      n_chk++;
      if (proto_err !== 1) begin
         $display("FAIL proto_set: perr=%b want 1", proto_err);
         n_fail++;
      end
      id_valid = 1; id_is_ctrl = 1;
      tick();
      clear_inputs();
      n_chk++;
      if (proto_err !== 1 || state !== BR_EX || ctrl_cnt !== 1) begin
         $display("FAIL proto_sticky: perr=%b st=%0d ctrl=%0d want 1,2,1",
                  proto_err, state, ctrl_cnt);
         n_fail++;
      end
      #2 reset = 0;
      #1;
      n_chk++;
      if (state !== FILL || proto_err !== 0 || ctrl_cnt !== 0 ||
          stall_cnt !== 0 || pc_en !== 0) begin
         $display("FAIL async_reset: st=%0d perr=%b ctrl=%0d stall=%0d pc=%b",
                  state, proto_err, ctrl_cnt, stall_cnt, pc_en);
         n_fail++;
      end
      tick();
      reset = 1;
   endtask

   task automatic test_saturate();
      reset_to_run();
      set_load_use_a();
      repeat (20) tick();
      clear_inputs();
      #1;
      n_chk++;
      if (stall_cnt !== 16'd20) begin
         $display("FAIL stall_20: got %0d want 20", stall_cnt);
         n_fail++;
      end
      n_chk++;
      if (s_stall_cnt !== 4'd15) begin
         $display("FAIL stall_sat4: got %0d want 15", s_stall_cnt);
         n_fail++;
      end
      set_load_use_a();
      tick();
      clear_inputs();
      n_chk++;
      if (s_stall_cnt !== 4'd15 || stall_cnt !== 16'd21) begin
         $display("FAIL stall_no_wrap: cnt4=%0d cnt16=%0d want 15,21",
                  s_stall_cnt, stall_cnt);
         n_fail++;
      end
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_load_use();
      test_ctrl();
      test_load_and_ctrl();
      test_halt();
      test_halt_drop();
      test_proto_err_and_reset();
      test_saturate();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central sequencer for the 5-stage 8-bit two-register (A/B) CPU with 10-bit PC.
- Drives PC and pipeline-register enable/bubble controls for: post-reset fill, load-use stalls, control-transfer waits (branches/jumps resolve in MEM), and halt/drain.
- Sits beside the datapath. It takes decoded per-stage flags and returns enables only; it does not touch data.

Parameters:
- FILL_CYCLES, 4, cycles of forced bubbles after reset release; clears pipeline registers that lack reset.
- DRAIN_CYCLES, 3, cycles of bubbles injected before entering HALTED.
- CNT_W, 16, width of the saturating performance counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real (non-bubble) instruction.
- id_reads_a  in  1  ID instruction reads register A (ALU operand or status).
- id_reads_b  in  1  ID instruction reads register B.
- id_is_ctrl  in  1  ID instruction is a jump or conditional branch.
- ex_valid  in  1  EX holds a real instruction.
- ex_writes_a  in  1  EX instruction writes A.
- ex_writes_b  in  1  EX instruction writes B.
- ex_is_load  in  1  EX instruction writes back memory data.
- mem_redirect  in  1  taken branch or jump in MEM; PC mux selects the new PC.
- halt_req  in  1  level request to stop fetch.
- pc_en  out  1  PC/fetch advance.
- if_id_en  out  1  IF/ID register load enable.
- if_id_bubble  out  1  load NOP into IF/ID.
- id_ex_bubble  out  1  load NOP controls into ID/EX.
- state  out  3  current FSM state.
- halted  out  1  high in HALTED.
- proto_err  out  1  sticky; mem_redirect seen outside BR_MEM.
- stall_cnt  out  CNT_W  cycles with pc_en=0 in RUN, BR_EX or BR_MEM.
- ctrl_cnt  out  CNT_W  control transfers entered.

Behaviour:
- States: FILL=0, RUN=1, BR_EX=2, BR_MEM=3, DRAIN=4, HALTED=5. Encodings 6 and 7 go to FILL.
- Reset low, asynchronous:
  - state=FILL; fill/drain counter=0.
  - pc_en=0, if_id_en=0, if_id_bubble=1, id_ex_bubble=1.
  - halted=0, proto_err=0, both counters 0.
- FILL:
  - Outputs hold their reset values for FILL_CYCLES cycles after reset release, then RUN.
  - Reset asserted mid-operation from any state returns here immediately.
- RUN, evaluated in priority order:
  1. Load-use: load_use = id_valid & ex_valid & ex_is_load & ((id_reads_a & ex_writes_a) | (id_reads_b & ex_writes_b)). When set: pc_en=0, if_id_en=0, id_ex_bubble=1, stay in RUN. This gives exactly one stall per hazard; MEM forwarding covers the next cycle.
  2. Control transfer: id_valid & id_is_ctrl. The instruction advances to EX (id_ex_bubble=0), with pc_en=0, if_id_en=1, if_id_bubble=1 (the wrong-path fetch is squashed). ctrl_cnt++. Go to BR_EX.
  3. Halt: halt_req (only when neither of the above applies). Go to DRAIN with counter=0.
  4. Otherwise: pc_en=1, if_id_en=1, no bubbles.
- BR_EX: pc_en=0, if_id_bubble=1, id_ex_bubble=0 (passes the bubble along). Go to BR_MEM.
- BR_MEM:
  - pc_en=1, if_id_en=1, no bubbles.
  - The PC loads the redirect target if mem_redirect, else sequential.
  - Go to RUN. halt_req is ignored until RUN.
- Control-transfer penalty is fixed at 2 bubbles, taken or not.
- DRAIN: pc_en=0, if_id_bubble=1, id_ex_bubble=1 for DRAIN_CYCLES cycles, then HALTED.
- HALTED:
  - halted=1, pc_en=0, if_id_en=0, bubbles=1.
  - halt_req low: next cycle RUN with halted=0.
- halt_req dropped during DRAIN: DRAIN still completes, then HALTED exits on the following cycle.
- proto_err: set on mem_redirect in any state other than BR_MEM; cleared only by reset.
- Counters saturate at 2^CNT_W-1 and never wrap.
- All outputs are combinational from state plus inputs, except the counters, halted and proto_err, which are registered.

Decomposition:
- Package pipe_ctrl_pkg: state encodings, a NOP opcode constant, and defaults for FILL_CYCLES and DRAIN_CYCLES.
- Sub-module sat_counter (parameter W; inc, clear, count), instantiated twice.

Test Plan:
- Reset low 3 cycles, then release → state=FILL and pc_en=0 for exactly 4 cycles; RUN on the 5th; counters=0.
- RUN, ex_is_load=1, ex_writes_a=1, id_reads_a=1 (both valid) → one cycle of pc_en=0, if_id_en=0, id_ex_bubble=1; stall_cnt=1; pc_en=1 on the next cycle.
- id_is_ctrl=1 in RUN, mem_redirect=1 in BR_MEM → states RUN→BR_EX→BR_MEM→RUN; pc_en pattern 0,0,1; ctrl_cnt=1; stall_cnt=2; proto_err=0.
- Load-use and id_is_ctrl together → load stall first, BR_EX the cycle after; ctrl_cnt counts once.
- halt_req=1 in RUN → 3 DRAIN cycles, then halted=1; halt_req=0 → RUN next cycle, pc_en=1.
- mem_redirect=1 in RUN → proto_err=1 and stays set; reset low mid-BR_EX → immediate FILL, proto_err=0, counters 0; CNT_W=4 with 20 stalls → stall_cnt=15.
